// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the control sequencer and the data memory.
// Revision 1.0 - initial release.
`default_nettype none

interface data_mem_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            operation;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   byte_en;
   logic                  resp_valid;
   logic [DATA_W-1:0]     load_value;
   logic                  resp_err;

   modport master (
      output req_valid, operation, address, wdata, byte_en,
      input  req_ready, resp_valid, load_value, resp_err
   );

   modport slave (
      input  req_valid, operation, address, wdata, byte_en,
      output req_ready, resp_valid, load_value, resp_err
   );
endinterface

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle word memory with byte-enable writes, fixed access latency and range check.
// Revision 1.0 - initial release.
`default_nettype none

module data_mem_ctrl #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 2
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   data_mem_ctrl_if.slave   bus
);
   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CMP_W = (ADDR_W > 32) ? ADDR_W + 1 : 33;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;

   logic [1:0]          r_state;
   logic [3:0]          r_cnt;
   logic [1:0]          r_op;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [NB-1:0]       r_be;
   logic [DATA_W-1:0]   r_load;
   logic                r_err;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_access;
   logic                w_in_range;
   logic                w_rd;
   logic                w_wr;
   logic [IDX_W-1:0]    w_idx;

   // Range check at full address width so high address bits never alias into the array.
   assign w_in_range = (CMP_W'(r_addr) < CMP_W'(DEPTH));
   assign w_idx      = r_addr[IDX_W-1:0];
   assign w_rd       = (r_op == OP_READ);
   assign w_wr       = (r_op == OP_WRITE);
   assign w_access   = (r_state == S_BUSY) && (r_cnt == 4'd0);

   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.resp_valid = (r_state == S_RESP);
   assign bus.load_value = r_load;
   assign bus.resp_err   = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_op    <= 2'b00;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_load  <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_op    <= bus.operation;
                  r_addr  <= bus.address;
                  r_wdata <= bus.wdata;
                  r_be    <= bus.byte_en;
                  r_cnt   <= 4'(LATENCY - 1);
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_err   <= (w_rd || w_wr) && !w_in_range;
                  if (w_rd) begin
                     r_load <= w_in_range ? r_mem[w_idx] : '0;
                  end
                  r_state <= S_RESP;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Commit is gated by the live FSM state, so an asynchronous reset during BUSY cancels the write.
   always_ff @(posedge clk) begin
      if (w_access && w_wr && w_in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (r_be[i]) begin
               r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed and random requests checked against a word-array model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_data_mem_ctrl;
   localparam logic [1:0] RD  = 2'b01;
   localparam logic [1:0] WR  = 2'b10;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [31:0] mdl  [256];
   logic [31:0] mdl1 [256];
   logic [31:0] m_load;
   logic [31:0] m_load1;

   data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(40)) b  ();
   data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b1 ();

   data_mem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(40), .LATENCY(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   data_mem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .LATENCY(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: each request is resolved against a plain word array.
   task automatic model(input logic [1:0] op, input logic [63:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, inout logic [31:0] mem [256], inout logic [31:0] ld,
                        output logic e_err);
      int idx;
      idx   = int'(addr[7:0]);
      e_err = (op == RD || op == WR) && (addr >= 64'd256);
      if (op == RD) ld = (addr < 64'd256) ? mem[idx] : 32'h0;
      if (op == WR && addr < 64'd256)
         for (int i = 0; i < 4; i++) if (be[i]) mem[idx][8*i +: 8] = wd[8*i +: 8];
   endtask

   task automatic req(input logic [1:0] op, input logic [39:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input string tag, output logic [31:0] lv);
      logic e_err;
      logic rdy_seen;
      int   n;
      model(op, 64'(addr), wd, be, mdl, m_load, e_err);
      b.operation = op; b.address = addr; b.wdata = wd; b.byte_en = be; b.req_valid = 1'b1;
      chk({tag, ":ready_idle"}, 64'(b.req_ready), 64'd1);
      @(posedge clk); #1;
      b.req_valid = 1'b0;
      b.address   = {8'($urandom), $urandom};
      b.wdata     = $urandom;
      b.byte_en   = 4'($urandom);
      b.operation = 2'($urandom);
      n = 0; rdy_seen = 1'b0;
      while (!b.resp_valid && n < 20) begin
         rdy_seen |= b.req_ready;
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ":latency"}, 64'(n), 64'd2);
      chk({tag, ":ready_busy"}, 64'(rdy_seen | b.req_ready), 64'd0);
      chk({tag, ":load"}, 64'(b.load_value), 64'(m_load));
      chk({tag, ":err"}, 64'(b.resp_err), 64'(e_err));
      lv = b.load_value;
      @(posedge clk); #1;
      chk({tag, ":pulse"}, 64'(b.resp_valid), 64'd0);
      chk({tag, ":ready_after"}, 64'(b.req_ready), 64'd1);
   endtask

   task automatic req1(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input string tag);
      logic e_err;
      int   n;
      model(op, 64'(addr), wd, be, mdl1, m_load1, e_err);
      b1.operation = op; b1.address = addr; b1.wdata = wd; b1.byte_en = be; b1.req_valid = 1'b1;
      @(posedge clk); #1;
      b1.req_valid = 1'b0;
      b1.address   = $urandom;
      n = 0;
      while (!b1.resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ":latency"}, 64'(n), 64'd1);
      chk({tag, ":load"}, 64'(b1.load_value), 64'(m_load1));
      chk({tag, ":err"}, 64'(b1.resp_err), 64'(e_err));
      @(posedge clk); #1;
      chk({tag, ":ready_after"}, 64'(b1.req_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] lv;
      logic [31:0] v;
      logic [39:0] a;
      logic        e_err;
      int          n;
      total = 0; bad = 0; m_load = 32'h0; m_load1 = 32'h0;
      b.req_valid  = 1'b0; b.operation  = 2'b00; b.address  = '0; b.wdata  = '0; b.byte_en  = '0;
      b1.req_valid = 1'b0; b1.operation = 2'b00; b1.address = '0; b1.wdata = '0; b1.byte_en = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("reset:ready", 64'(b.req_ready), 64'd1);
      chk("reset:resp_valid", 64'(b.resp_valid), 64'd0);
      chk("reset:err", 64'(b.resp_err), 64'd0);
      chk("reset:load", 64'(b.load_value), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Read path and byte-enable merge.
      req(WR, 40'd2, 32'h00000003, 4'hF, "preload2", lv);
      req(RD, 40'd2, 32'h0, 4'h0, "read2", lv);
      chk("read2:const", 64'(lv), 64'h3);
      req(WR, 40'd5, 32'h11223344, 4'hF, "preload5", lv);
      req(WR, 40'd5, 32'hAABBCCDD, 4'b0101, "bewrite5", lv);
      req(RD, 40'd5, 32'h0, 4'h0, "read5", lv);
      chk("read5:const", 64'(lv), 64'h11BB33DD);
      req(WR, 40'd5, 32'hFFFFFFFF, 4'h0, "be_zero", lv);
      req(RD, 40'd5, 32'h0, 4'h0, "read5b", lv);

      // Out-of-range accesses, including an address that would alias word 0 if truncated.
      req(WR, 40'd0, 32'hCAFEF00D, 4'hF, "preload0", lv);
      req(RD, 40'd256, 32'h0, 4'h0, "oor_read", lv);
      chk("oor_read:const", 64'(lv), 64'h0);
      req(WR, 40'h01_0000_0000, 32'hFFFFFFFF, 4'hF, "oor_write", lv);
      req(RD, 40'd0, 32'h0, 4'h0, "read0", lv);
      chk("read0:const", 64'(lv), 64'hCAFEF00D);

      // Back-to-back with req_valid held: the second request waits for IDLE.
      v = $urandom;
      model(WR, 64'd7, v, 4'hF, mdl, m_load, e_err);
      b.operation = WR; b.address = 40'd7; b.wdata = v; b.byte_en = 4'hF; b.req_valid = 1'b1;
      @(posedge clk); #1;
      b.operation = RD; b.address = 40'd7; b.wdata = ~v;
      n = 0;
      while (!b.req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b:ready_return", 64'(n), 64'd3);
      @(posedge clk); #1;
      b.req_valid = 1'b0; b.address = 40'd300;
      n = 0;
      while (!b.resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b:latency", 64'(n), 64'd2);
      chk("b2b:load", 64'(b.load_value), 64'(v));
      chk("b2b:err", 64'(b.resp_err), 64'd0);
      m_load = v;
      @(posedge clk); #1;

      // Asynchronous reset during BUSY abandons the write.
      req(WR, 40'd3, 32'h0, 4'hF, "preload3", lv);
      req(RD, 40'd5, 32'h0, 4'h0, "read5c", lv);
      b.operation = WR; b.address = 40'd3; b.wdata = 32'h12345678; b.byte_en = 4'hF; b.req_valid = 1'b1;
      @(posedge clk); #1;
      b.req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst:ready", 64'(b.req_ready), 64'd1);
      chk("midrst:resp_valid", 64'(b.resp_valid), 64'd0);
      chk("midrst:err", 64'(b.resp_err), 64'd0);
      chk("midrst:load", 64'(b.load_value), 64'd0);
      m_load = 32'h0; m_load1 = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      req(RD, 40'd3, 32'h0, 4'h0, "read3", lv);
      chk("read3:const", 64'(lv), 64'h0);

      // Random traffic over a preloaded window plus out-of-range addresses.
      for (int i = 0; i < 16; i++) req(WR, 40'(i), $urandom, 4'hF, "rnd_pre", lv);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) a = 40'd256 + 40'($urandom_range(0, 2000));
         else if ($urandom_range(0, 9) == 0) a = {8'($urandom_range(1, 255)), 32'($urandom_range(0, 15))};
         else a = 40'($urandom_range(0, 15));
         req(2'($urandom_range(0, 3)), a, $urandom, 4'($urandom), "rnd", lv);
      end

      // Single-edge latency instance and NOP handling.
      v = $urandom | 32'h1;
      req1(WR, 32'd9, v, 4'hF, "l1_write");
      req1(RD, 32'd9, 32'h0, 4'h0, "l1_read");
      req1(2'b00, 32'd9, 32'h0, 4'hF, "l1_nop00");
      req1(2'b11, 32'd1000, 32'h0, 4'hF, "l1_nop11");
      req1(RD, 32'd300, 32'h0, 4'h0, "l1_oor");
      req1(2'b00, 32'd300, 32'h0, 4'h0, "l1_nop_oor");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, multi-cycle data memory for the MIPS datapath, serving the STATE_MEM phase of lw/sw.
- Generalised in width and depth, with configurable access latency.
- Adds word writes with byte enables, a valid/ready request handshake, a one-cycle response pulse, and out-of-range error reporting.
- The FSM/control sequencer issues one request per memory instruction and waits for resp_valid before advancing.

Parameters:
- DATA_W, 32: data word width in bits; must be a multiple of 8.
- DEPTH, 256: number of words in the array.
- ADDR_W, 32: width of the address input; the address is a word index.
- LATENCY, 2: edges from request acceptance to resp_valid rise; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- operation  in  2  `MEM_READ` = 2'b01, `MEM_WRITE` = 2'b10; 2'b00 and 2'b11 are NOP.
- address  in  ADDR_W  word index (ALU result).
- wdata  in  DATA_W  store data.
- byte_en  in  DATA_W/8  per-byte write enable; ignored on reads.
- resp_valid  out  1  one-cycle response strobe.
- load_value  out  DATA_W  read data; held until the next read response.
- resp_err  out  1  qualified by resp_valid; high when the address was out of range.

Behaviour:
- Clocking: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: FSM = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, load_value = 0, latency counter = 0. Array contents are not reset; simulation initialises them to 0.
- Reset mid-operation: an in-flight request is abandoned. A write not yet committed is never committed.
- States:
  - IDLE: req_ready = 1. On an edge with req_valid = 1, latch operation, address, wdata and byte_en, load cnt = LATENCY-1, then go to BUSY.
  - BUSY: req_ready = 0. When cnt != 0, decrement. When cnt == 0, perform the access at this edge and go to RESP.
  - RESP: resp_valid = 1 for exactly this cycle, req_ready = 0. Next edge returns to IDLE.
- Timing:
  - resp_valid rises LATENCY edges after the acceptance edge.
  - Back-to-back throughput is one request per LATENCY+1 cycles.
  - req_valid is ignored outside IDLE.
- Read: load_value <= array[address] at the access edge. Other responses leave load_value unchanged.
- Write: for each lane i with byte_en[i] = 1, array[address][8i+7:8i] <= wdata lane i. Lanes with byte_en[i] = 0 are untouched. byte_en = 0 means no change but still gives a response.
- NOP: runs the full handshake with no array access and resp_err = 0.
- Out of range (address >= DEPTH, compared at the full ADDR_W width with no truncation or wrap):
  - Reads return load_value = 0.
  - Writes are dropped.
  - resp_err = 1 with the response.
- Read-after-write: a read accepted after a write's response sees the written data.
- Latched inputs: changes to the request inputs after acceptance have no effect.

Test Plan:
- Reset and read:
  - Deassert rst_n, preload word 2 = 0x00000003, read address 2 with LATENCY = 2.
  - resp_valid high exactly 2 edges after acceptance, for one cycle; load_value = 0x00000003; resp_err = 0; req_ready low from acceptance until the cycle after the response.
- Byte-enable write:
  - Write 0xAABBCCDD with byte_en = 4'b0101 to address 5, which holds 0x11223344; then read address 5.
  - load_value = 0x11BB33DD.
- Out of range:
  - Read address 256 with DEPTH = 256.
  - resp_err = 1 and load_value = 0.
  - Then write 0xFFFFFFFF to address 0x1_0000_0000 modulo ADDR_W. Word 0 is unchanged and resp_err = 1.
- Back-to-back with input changes:
  - Hold req_valid high and issue a write to address 7 then a read of address 7.
  - The second request is accepted only in IDLE, LATENCY+1 cycles after the first.
  - Read returns the written value.
  - Changing address during BUSY has no effect.
- Reset mid-operation:
  - Assert rst_n low during BUSY of a write of 0x12345678 to address 3, which holds 0.
  - Outputs go to reset values immediately without waiting for clk; a later read of address 3 returns 0.
- LATENCY = 1 and NOP:
  - Read gives resp_valid on the first edge after acceptance.
  - operation = 2'b00 gives resp_valid with resp_err = 0 and load_value unchanged.
